piradspi_miso_packer: RTL and testbench
=======================================

// Module: piradspi_miso_packer
// PURPOSE
//  Downstream of the SPI shift engine: collects MISO bits sampled per transfer and packs them
//  into DATA_WIDTH-bit words for the MISO FIFO read through REGISTER_MISOFIFO. Word count and
//  final-word alignment follow the profile XFERLEN latched at command start. Engine cannot be
//  stalled (SCLK free-running), so overruns are flagged, never back-pressured.
// PARAMETERS
//  DATA_WIDTH   32  output word width (matches CSR data width)
//  LEN_WIDTH    16  width of xfer_len (bits per command)
//  CMD_ID_WIDTH 8   width of cmd_id tag
// PORTS
//  clk        in   1             clock; all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  start      in   1             1-cycle pulse: new command begins, latches xfer_len/cmd_id
//  xfer_len   in   LEN_WIDTH     bits in this command (1..2^LEN_WIDTH-1)
//  cmd_id     in   CMD_ID_WIDTH  command tag
//  bit_valid  in   1             1-cycle strobe: bit_data is a sampled MISO bit
//  bit_data   in   1             sampled MISO bit, MSB-first per command
//  m_valid    out  1             output word valid
//  m_ready    in   1             MISO FIFO can accept
//  m_data     out  DATA_WIDTH    packed word
//  m_last     out  1             word is the final word of the command
//  busy       out  1             command in progress or word pending
//  done       out  1             1-cycle pulse when last word of command accepted
//  overrun    out  1             sticky: a completed word was lost (holding reg full)
//  clr_overrun in  1             clears overrun (CSR write-1-to-clear)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, shift reg/counters 0. Reset mid-command discards all.
//  - States: IDLE -> (start) SHIFT -> (bit count == xfer_len) FLUSH -> (hold reg free) IDLE.
//  - start in SHIFT/FLUSH: ignored, no state change (engine guarantees serialisation).
//  - start with xfer_len==0: no words, done pulses next cycle, stays IDLE.
//  - SHIFT: per bit_valid, shift = {shift[DATA_WIDTH-2:0], bit_data}; bit_cnt++ ; word_cnt
//    bits mod DATA_WIDTH. bit_valid in IDLE is ignored.
//  - Word complete when DATA_WIDTH bits shifted or final bit of command; final partial word
//    is right-aligned (LSB = last bit), upper bits zero. E.g. 24 bits -> 0x00XXXXXX.
//  - Completed word moves to holding reg in the cycle after the completing strobe; m_valid
//    asserts that cycle. Latency: completing bit_valid -> m_valid = 1 clk.
//  - Handshake: transfer when m_valid & m_ready; m_data/m_last stable while m_valid & !m_ready.
//    m_valid may drop only after transfer. Back-to-back: new word may load in transfer cycle.
//  - Overrun: word completes while holding reg full and not transferring that cycle -> new
//    word dropped, overrun set; if dropped word was last, done still pulses after pending
//    word drains. clr_overrun and a new overrun same cycle: overrun stays 1.
//  - Bits after xfer_len reached (FLUSH) ignored. done pulses the cycle after last-word xfer.
//  - bit_cnt/word count widths sized from LEN_WIDTH; no wrap within a legal command.
//  - busy = (state != IDLE) | m_valid.
// CONFIGURATION
//  PIRADSPI_MISO_CMDID_EN defined: after the last data word, one extra tag word
//   {DATA_WIDTH-CMD_ID_WIDTH-LEN_WIDTH zeros, cmd_id, xfer_len} is emitted; m_last moves to tag
//   word; done follows tag acceptance. Tag word subject to same overrun rule.
//  Not defined: no tag word; m_last on final data word; cmd_id port present but unused.
// TESTING
//  - xfer_len=32, bits of 0xA5A6A7A8 MSB-first, m_ready=1 -> one word 0xA5A6A7A8, m_last=1, done.
//  - xfer_len=24, slave bits 0x010203 -> one word 0x00010203, m_last=1.
//  - xfer_len=48, bits 0x010203040506 -> 0x01020304 (m_last=0), then 0x00000506 (m_last=1).
//  - xfer_len=96, m_ready=0 throughout -> first word held stable, second/third dropped,
//    overrun=1; clr_overrun -> 0; m_ready=1 -> only word 1 delivered.
//  - rst asserted after 10 bits of a 32-bit command -> all outputs 0; next start 8 bits 0xFF
//    -> 0x000000FF, no residue from aborted command.
//  - With PIRADSPI_MISO_CMDID_EN, xfer_len=40, cmd_id=1 -> 2 data words then tag 0x00010028
//    with m_last=1; without macro, m_last on 2nd data word.

Source files
------------

// File: rtl/piradspi_miso_packer_if.sv
// Stream and control bundle between the SPI engine/CSR side and the MISO packer.
// Build option for the packer: PIRADSPI_MISO_CMDID_EN (appends a tag word per command).
interface piradspi_miso_packer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int CMD_ID_WIDTH = 8
);
    logic                    start;
    logic [LEN_WIDTH-1:0]    xfer_len;
    logic [CMD_ID_WIDTH-1:0] cmd_id;
    logic                    bit_valid;
    logic                    bit_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_last;
    logic                    busy;
    logic                    done;
    logic                    overrun;
    logic                    clr_overrun;

    // Output stream: a word moves on every rising edge where m_valid & m_ready.
    // While m_valid & !m_ready, m_data/m_last hold steady and m_valid stays high;
    // m_valid only falls after a transfer. m_ready may be driven freely.
    modport master (
        output start, xfer_len, cmd_id, bit_valid, bit_data, m_ready, clr_overrun,
        input  m_valid, m_data, m_last, busy, done, overrun
    );

    modport slave (
        input  start, xfer_len, cmd_id, bit_valid, bit_data, m_ready, clr_overrun,
        output m_valid, m_data, m_last, busy, done, overrun
    );
endinterface

// File: rtl/piradspi_miso_packer.sv
// Packs sampled MISO bits MSB-first into DATA_WIDTH-bit words with a one-word holding register.
// Define PIRADSPI_MISO_CMDID_EN to emit a {cmd_id, xfer_len} tag word after each command.
module piradspi_miso_packer #(
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int CMD_ID_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    piradspi_miso_packer_if.slave      bus,
    output logic [1:0]                 dbg_state
);
    localparam int WCW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [WCW-1:0]          wcnt;
    logic [LEN_WIDTH-1:0]    bit_cnt;
    logic [LEN_WIDTH-1:0]    len_q;
    logic                    tag_pend;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    done_q;
    logic                    ovr_q;

    logic                    xfer;
    logic                    hold_free;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic [LEN_WIDTH-1:0]    bit_cnt_nxt;
    logic                    final_bit;
    logic                    word_full;
    logic                    take_bit;
    logic                    word_done;
    logic                    emit_tag;
    logic                    new_word;
    logic [DATA_WIDTH-1:0]   new_data;
    logic                    new_last;
    logic                    drop;
    logic [DATA_WIDTH-1:0]   tag_word;

`ifdef PIRADSPI_MISO_CMDID_EN
    localparam bit TAG_EN = 1'b1;
    localparam int PAD    = DATA_WIDTH - CMD_ID_WIDTH - LEN_WIDTH;
    logic [CMD_ID_WIDTH-1:0] id_q;
    assign tag_word = {{PAD{1'b0}}, id_q, len_q};
`else
    localparam bit TAG_EN = 1'b0;
    assign tag_word = '0;
`endif

    always_comb begin
        xfer        = m_valid_q & bus.m_ready;
        hold_free   = ~m_valid_q | bus.m_ready;
        shift_nxt   = {shift_q[DATA_WIDTH-2:0], bus.bit_data};
        bit_cnt_nxt = bit_cnt + 1'b1;
        final_bit   = (bit_cnt_nxt == len_q);
        word_full   = (wcnt == WCW'(DATA_WIDTH - 1));
        take_bit    = (state == SHIFT) & bus.bit_valid;
        word_done   = take_bit & (final_bit | word_full);
        emit_tag    = (state == FLUSH) & tag_pend;
        new_word    = word_done | emit_tag;
        new_data    = emit_tag ? tag_word : shift_nxt;
        new_last    = emit_tag | (final_bit & ~TAG_EN);
        // A completed word with nowhere to go is lost; the engine cannot be stalled.
        drop        = new_word & ~hold_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            wcnt      <= '0;
            bit_cnt   <= '0;
            len_q     <= '0;
            tag_pend  <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef PIRADSPI_MISO_CMDID_EN
            id_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;

            if (drop) begin
                ovr_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                ovr_q <= 1'b0;
            end

            if (new_word && hold_free) begin
                m_valid_q <= 1'b1;
                m_data_q  <= new_data;
                m_last_q  <= new_last;
            end else if (xfer) begin
                m_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.xfer_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            len_q    <= bus.xfer_len;
                            bit_cnt  <= '0;
                            wcnt     <= '0;
                            shift_q  <= '0;
                            tag_pend <= 1'b0;
`ifdef PIRADSPI_MISO_CMDID_EN
                            id_q     <= bus.cmd_id;
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (bus.bit_valid) begin
                        bit_cnt <= bit_cnt_nxt;
                        // Clearing the shifter per word right-aligns a short final word.
                        if (word_done) begin
                            shift_q <= '0;
                            wcnt    <= '0;
                        end else begin
                            shift_q <= shift_nxt;
                            wcnt    <= wcnt + 1'b1;
                        end
                        if (final_bit) begin
                            state    <= FLUSH;
                            tag_pend <= TAG_EN;
                        end
                    end
                end
                FLUSH: begin
                    if (tag_pend) begin
                        tag_pend <= 1'b0;
                    end else if (hold_free) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.done    = done_q;
    assign bus.overrun = ovr_q;
    assign bus.busy    = (state != IDLE) | m_valid_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_piradspi_miso_packer.sv
// Randomized bench for piradspi_miso_packer against a word-level reference model.
// Works with or without PIRADSPI_MISO_CMDID_EN defined.
module tb_piradspi_miso_packer;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    piradspi_miso_packer_if #(.DATA_WIDTH(32), .LEN_WIDTH(16), .CMD_ID_WIDTH(8)) bus ();

    piradspi_miso_packer #(.DATA_WIDTH(32), .LEN_WIDTH(16), .CMD_ID_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected words of the current command, in emission order.
    logic [31:0] exp_q[$];
    bit          last_q[$];

    // Reference model state (as seen after the most recent rising edge).
    bit          mh_full;
    logic [31:0] mh_word;
    bit          mh_last;
    bit          ex_done;
    bit          ex_ov;
    bit          in_cmd;
    int          cur_len;
    int          bits_sent;
    int          wi;
    bit          tag_due;
    bit          all_prod;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh_full = 0; mh_word = '0; mh_last = 0; ex_done = 0; ex_ov = 0;
        in_cmd = 0; cur_len = 0; bits_sent = 0; wi = 0; tag_due = 0; all_prod = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit st, input int len, input bit bv, input bit rdy, input bit clr);
        bit xfer, have, drop, nd;
        logic [31:0] w;
        bit l;
        xfer = mh_full && rdy;
        have = 0; nd = 0; w = '0; l = 0;
        if (in_cmd) begin
            if (tag_due) begin
                have = 1; w = exp_q[wi]; l = last_q[wi]; wi++;
                tag_due = 0; all_prod = 1;
            end else if (!all_prod) begin
                if (bv) begin
                    bits_sent++;
                    if (bits_sent % 32 == 0 || bits_sent == cur_len) begin
                        have = 1; w = exp_q[wi]; l = last_q[wi]; wi++;
                        if (bits_sent == cur_len) begin
                            if (wi < exp_q.size()) tag_due = 1;
                            else all_prod = 1;
                        end
                    end
                end
            end else if (xfer) begin
                nd = 1; in_cmd = 0;
            end
        end else if (st) begin
            if (len == 0) begin
                nd = 1;
            end else begin
                in_cmd = 1; cur_len = len; bits_sent = 0; wi = 0; tag_due = 0; all_prod = 0;
            end
        end
        drop = have && mh_full && !rdy;
        if (have && !drop) begin
            mh_full = 1; mh_word = w; mh_last = l;
        end else if (xfer) begin
            mh_full = 0;
        end
        ex_ov   = drop ? 1'b1 : (clr ? 1'b0 : ex_ov);
        ex_done = nd;
    endtask

    task automatic check_outputs();
        check_eq("m_valid", bus.m_valid, mh_full);
        if (mh_full) begin
            check_eq("m_data", bus.m_data, mh_word);
            check_eq("m_last", bus.m_last, mh_last);
        end
        check_eq("done", bus.done, ex_done);
        check_eq("overrun", bus.overrun, ex_ov);
        check_eq("busy", bus.busy, in_cmd || mh_full);
    endtask

    // driver: apply inputs for one cycle, step the model, check after the edge
    task automatic step(input bit st, input int len, input logic [7:0] id, input bit bv,
                        input bit bd, input bit rdy, input bit clr);
        bus.start       = st;
        bus.xfer_len    = len[15:0];
        bus.cmd_id      = id;
        bus.bit_valid   = bv;
        bus.bit_data    = bd;
        bus.m_ready     = rdy;
        bus.clr_overrun = clr;
        model_edge(st, len, bv, rdy, clr);
        @(negedge clk);
        check_outputs();
    endtask

    // One command: build expected words from the bit list, then drive until drained.
    task automatic run_cmd(input int len, input logic [7:0] id, input logic [127:0] pat,
                           input bit use_pat, input int rdy_pct, input int bv_pct,
                           input int low_cycles, input int exp_words, input int abort_at);
        bit          bq[$];
        logic [31:0] w;
        int          cyc;
        int          obs;
        bit          rdy, bv, bd, clr, st;
        bq.delete(); exp_q.delete(); last_q.delete();
        for (int i = 0; i < len; i++)
            bq.push_back(use_pat ? pat[len-1-i] : 1'($urandom_range(1)));
        for (int k = 0; k < len; k += 32) begin
            w = '0;
            for (int j = k; j < len && j < k + 32; j++) w = (w << 1) | 32'(bq[j]);
            exp_q.push_back(w);
`ifdef PIRADSPI_MISO_CMDID_EN
            last_q.push_back(1'b0);
`else
            last_q.push_back(k + 32 >= len);
`endif
        end
`ifdef PIRADSPI_MISO_CMDID_EN
        if (len > 0) begin
            exp_q.push_back({8'h00, id, len[15:0]});
            last_q.push_back(1'b1);
        end
`endif
        obs = 0;
        rdy = (low_cycles > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        step(1'b1, len, id, 1'b0, 1'b0, rdy, 1'b0);
        cyc = 0;
        while ((in_cmd || mh_full) && cyc < 5000) begin
            if (abort_at >= 0 && bits_sent == abort_at) break;
            rdy = (cyc < low_cycles) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            bv  = ($urandom_range(99) < bv_pct);
            bd  = (bits_sent < len) ? bq[bits_sent] : 1'($urandom_range(1));
            clr = (low_cycles > 0 && cyc == low_cycles - 1) || (rdy_pct < 100 && $urandom_range(31) == 0);
            st  = (bits_sent > 0 && bits_sent < len && $urandom_range(15) == 0);
            if (bus.m_valid && rdy) obs++;
            step(st, st ? int'($urandom_range(1, 40)) : len, id, bv, bd, rdy, clr);
            cyc++;
        end
        if (cyc >= 5000) check_eq("timeout", 32'd1, 32'd0);
        if (abort_at < 0) begin
            step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        if (exp_words >= 0) check_eq("words_out", obs, exp_words);
    endtask

    initial begin
        int len;
        rst = 1'b1;
        bus.start = 0; bus.xfer_len = '0; bus.cmd_id = '0; bus.bit_valid = 0;
        bus.bit_data = 0; bus.m_ready = 0; bus.clr_overrun = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs();
        check_eq("rst_mdata", bus.m_data, 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);

        // directed cases
        run_cmd(32, 8'h00, 128'hA5A6A7A8, 1, 100, 100, 0, -1, -1);
        run_cmd(24, 8'h00, 128'h010203, 1, 100, 100, 0, -1, -1);
        run_cmd(48, 8'h00, 128'h010203040506, 1, 100, 100, 0, -1, -1);
        run_cmd(96, 8'h00, 128'h1111_2222_3333_4444_5555_6666, 1, 100, 100, 110, 1, -1);
        run_cmd(40, 8'h01, 128'hDE_ADBE_EF01, 1, 100, 100, 0, -1, -1);
        run_cmd(0, 8'h07, 128'h0, 1, 100, 100, 0, 0, -1);

        // abort mid-command with reset, then a clean short command
        run_cmd(32, 8'h00, 128'hFFFF_FFFF, 1, 100, 100, 0, -1, 10);
        rst = 1'b1;
        bus.start = 0; bus.bit_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
        check_eq("abort_mdata", bus.m_data, 32'h0);
        run_cmd(8, 8'h00, 128'hFF, 1, 100, 100, 0, 1, -1);

        // randomized commands
        for (int n = 0; n < 30; n++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 160));
            run_cmd(len, 8'($urandom), 128'h0, 0, int'($urandom_range(50, 100)),
                    int'($urandom_range(30, 100)), 0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
